// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave: oversamples SCK/SS_n/MOSI into clk, receives MSB-first words on
// SCK rise and shifts a one-word-buffered tx word out on MISO at SCK fall.
module spi_slave_rx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_underrun,
    output logic              busy
);
    localparam int CW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t            state;
    logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
    logic              sck_d, ss_d;
    logic              sck_s, ss_s, mosi_s;
    logic              sck_rise, sck_fall, ss_rise, ss_fall;
    logic [CW-1:0]     bit_cnt;
    logic              got_rise;
    logic [DATA_W-1:0] rx_shift, tx_shift;
    logic [DATA_W-1:0] buf_data, load_word;
    logic              buf_full, load;

    // MOSI gets the same depth as SCK so it lines up with the detected rise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sck_sync  <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
            ss_d      <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sck_d     <= sck_sync[SYNC_STAGES-1];
            ss_d      <= ss_sync[SYNC_STAGES-1];
        end
    end

    always_comb begin
        sck_s     = sck_sync[SYNC_STAGES-1];
        ss_s      = ss_sync[SYNC_STAGES-1];
        mosi_s    = mosi_sync[SYNC_STAGES-1];
        sck_rise  = sck_s & ~sck_d;
        sck_fall  = ~sck_s & sck_d;
        ss_rise   = ss_s & ~ss_d;
        ss_fall   = ~ss_s & ss_d;
        // reload at selection, or at the fall that follows a completed word
        load      = ((state == IDLE) && ss_fall) ||
                    ((state == ACTIVE) && !ss_rise && sck_fall && (bit_cnt == '0) && got_rise);
        load_word = buf_full ? buf_data : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_ready    <= 1'b1;
            tx_underrun <= 1'b0;
            busy        <= 1'b0;
            bit_cnt     <= '0;
            got_rise    <= 1'b0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            buf_data    <= '0;
            buf_full    <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= load & ~buf_full;

            // accept only happens while empty, so a same-clk load has already drained it
            if (tx_valid && tx_ready) begin
                buf_data <= tx_data;
                buf_full <= 1'b1;
                tx_ready <= 1'b0;
            end else if (load) begin
                buf_full <= 1'b0;
                tx_ready <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (ss_fall) begin
                        state    <= ACTIVE;
                        bit_cnt  <= '0;
                        got_rise <= 1'b0;
                        tx_shift <= load_word;
                        miso     <= load_word[DATA_W-1];
                        miso_oe  <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (ss_rise) begin
                        state    <= IDLE;
                        bit_cnt  <= '0;
                        got_rise <= 1'b0;
                        miso     <= 1'b0;
                        miso_oe  <= 1'b0;
                        busy     <= 1'b0;
                    end else if (sck_rise) begin
                        rx_shift <= {rx_shift[DATA_W-2:0], mosi_s};
                        got_rise <= 1'b1;
                        if (bit_cnt == LAST) begin
                            bit_cnt  <= '0;
                            rx_data  <= {rx_shift[DATA_W-2:0], mosi_s};
                            rx_valid <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (sck_fall) begin
                        if (load) begin
                            tx_shift <= load_word;
                            miso     <= load_word[DATA_W-1];
                        end else if (bit_cnt != '0) begin
                            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                            miso     <= tx_shift[DATA_W-2];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
